// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package sub_pkg;

  localparam int unsigned DEFAULT_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/serial_subtractor_full_subtractor.sv
// One-bit full subtractor cell: d = a - b - bin, bout set when the bit borrows.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial A - B, LSB first, one bit per clock, behind valid/ready operand and result handshakes.
module serial_subtractor
  import sub_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Diff,
  output logic             Borrow,
  output logic             Ovf
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state_q;
  state_t           state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-2:0] d_sh_q;
  logic             bin_q;
  logic             a_msb_q;
  logic             b_msb_q;

  logic             accept_c;
  logic             last_c;
  logic             d_c;
  logic             bout_c;
  logic [WIDTH-1:0] dfull_c;

  full_subtractor u_fs (
    .a    (a_sh_q[0]),
    .b    (b_sh_q[0]),
    .bin  (bin_q),
    .d    (d_c),
    .bout (bout_c)
  );

  // Difference bits collected so far plus the bit being produced this cycle.
  assign dfull_c = {d_c, d_sh_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && in_ready) begin
          accept_c = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cnt_q == CW'(WIDTH - 1)) begin
          last_c  = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake flags follow the next state so neither has a combinational input path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      in_ready  <= (state_d == ST_IDLE);
      out_valid <= (state_d == ST_HOLD);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      d_sh_q  <= '0;
      bin_q   <= 1'b0;
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      Diff    <= '0;
      Borrow  <= 1'b0;
      Ovf     <= 1'b0;
    end else if (accept_c) begin
      cnt_q   <= '0;
      a_sh_q  <= A;
      b_sh_q  <= B;
      bin_q   <= 1'b0;
      a_msb_q <= A[WIDTH-1];
      b_msb_q <= B[WIDTH-1];
    end else if (state_q == ST_RUN) begin
      a_sh_q <= {1'b0, a_sh_q[WIDTH-1:1]};
      b_sh_q <= {1'b0, b_sh_q[WIDTH-1:1]};
      d_sh_q <= dfull_c[WIDTH-1:1];
      bin_q  <= bout_c;
      if (last_c) begin
        cnt_q  <= '0;
        Diff   <= dfull_c;
        Borrow <= bout_c;
        Ovf    <= (a_msb_q ^ b_msb_q) & (d_c ^ a_msb_q);
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule
